// File: rtl/multi_project_mux.sv
// Wishbone-controlled pad multiplexer: selects one of NUM_PROJECTS user designs onto the shared IO pads,
// with a guard interval (pads safe, all projects in reset) on every enable or project switch.
module multi_project_mux #(
  parameter logic [31:0] ADDR_BASE    = 32'h3000_0000,
  parameter int unsigned NUM_PROJECTS = 4,
  parameter int unsigned PADS         = 38,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_dat_i,
  input  logic [31:0]                  wbs_adr_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [PADS-1:0]              io_in,
  output logic [PADS-1:0]              io_out,
  output logic [PADS-1:0]              io_oeb,
  output logic [NUM_PROJECTS*PADS-1:0] proj_in,
  input  logic [NUM_PROJECTS*PADS-1:0] proj_out,
  input  logic [NUM_PROJECTS*PADS-1:0] proj_oeb,
  output logic [NUM_PROJECTS-1:0]      proj_rst
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic [7:0]              sel_q, sel_d;
  logic                    err_q, err_d;
  logic [7:0]              guard_q, guard_d;
  logic                    ack_q;
  logic [31:0]             rdata_q, rdata_d;
  logic [NUM_PROJECTS-1:0] proj_rst_q, proj_rst_d;

  logic       valid, hit, accept, wr;
  logic [1:0] reg_idx;
  logic       en_w;
  logic [7:0] sel_w;
  logic       sel_bad;
  logic       unused_bits;

  assign valid   = wbs_cyc_i & wbs_stb_i;
  assign hit     = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  // ack_q gates acceptance so a held strobe produces alternating acks
  assign accept  = valid & hit & ~ack_q;
  assign wr      = accept & wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];
  assign en_w    = wbs_sel_i[0] ? wbs_dat_i[0] : en_q;
  assign sel_w   = wbs_sel_i[1] ? wbs_dat_i[15:8] : sel_q;
  assign sel_bad = (32'(sel_w) >= NUM_PROJECTS);

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  always_comb begin
    en_d    = en_q;
    sel_d   = sel_q;
    err_d   = err_q;
    guard_d = guard_q;
    if (wr) begin
      case (reg_idx)
        2'd0: begin
          if (sel_bad) begin
            err_d = 1'b1;
          end else begin
            en_d  = en_w;
            sel_d = sel_w;
          end
        end
        2'd1: if (wbs_sel_i[0] && wbs_dat_i[0]) err_d = 1'b0;
        2'd2: if (wbs_sel_i[0]) guard_d = wbs_dat_i[7:0];
        default: ;
      endcase
    end
  end

  // Transitions are driven by the CTRL value change, so an identical rewrite is a no-op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en_q && !en_d) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (en_d && (!en_q || (sel_d != sel_q))) begin
      state_d = ST_GUARD;
      cnt_d   = guard_q;
    end else if (state_q == ST_GUARD) begin
      if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (accept && !wbs_we_i) begin
      case (reg_idx)
        2'd0: rdata_d = {16'b0, sel_q, 7'b0, en_q};
        2'd1: rdata_d = {29'b0, err_q, (state_q == ST_GUARD), (state_q == ST_RUN)};
        2'd2: rdata_d = {24'b0, guard_q};
        default: ;
      endcase
    end
  end

  // Reset outputs are registered from the next state so they align with the pad switch
  always_comb begin
    for (int unsigned p = 0; p < NUM_PROJECTS; p++) begin
      proj_rst_d[p] = !((state_d == ST_RUN) && (sel_d == 8'(p)));
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      guard_q    <= 8'(GUARD_CYCLES);
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      proj_rst_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      guard_q    <= guard_d;
      ack_q      <= accept;
      rdata_q    <= rdata_d;
      proj_rst_q <= proj_rst_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = ack_q ? rdata_q : '0;
  assign proj_rst  = proj_rst_q;
  assign proj_in   = {NUM_PROJECTS{io_in}};

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    if (state_q == ST_RUN) begin
      for (int unsigned p = 0; p < NUM_PROJECTS; p++) begin
        if (sel_q == 8'(p)) begin
          io_out = proj_out[p*PADS +: PADS];
          io_oeb = proj_oeb[p*PADS +: PADS];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_project_mux.sv
// Bench for multi_project_mux: directed scenarios then random bus traffic, checked against
// a cycle-count model of the enable/select/guard rules.
module tb_multi_project_mux;
  localparam int NP   = 4;
  localparam int PADS = 38;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       dat_i, adr;
  logic              ack;
  logic [31:0]       dat_o;
  logic [PADS-1:0]   io_in, io_out, io_oeb;
  logic [NP*PADS-1:0] proj_in, proj_out, proj_oeb;
  logic [NP-1:0]     proj_rst;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  // Model: guard runs for m_glen+1 cycles counted from the accepting edge m_entry
  logic       m_en, m_err;
  logic [7:0] m_sel, m_guard, m_glen;
  int         m_entry;
  bit         rand_pads;

  multi_project_mux #(
    .ADDR_BASE(BASE),
    .NUM_PROJECTS(NP),
    .PADS(PADS),
    .GUARD_CYCLES(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .proj_in(proj_in), .proj_out(proj_out), .proj_oeb(proj_oeb), .proj_rst(proj_rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_sel = '0; m_guard = 8'd16; m_err = 1'b0; m_entry = 0; m_glen = '0;
  endtask

  function automatic int exp_state();  // 0 idle, 1 guard, 2 run
    if (!m_en) return 0;
    if (cycle - m_entry <= int'(m_glen)) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int s = exp_state();
    if (a[31:4] != BASE[31:4]) return '0;
    case (a[3:2])
      2'd0: return {16'b0, m_sel, 7'b0, m_en};
      2'd1: return {29'b0, m_err, s == 1, s == 2};
      2'd2: return {24'b0, m_guard};
      default: return '0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic       n_en;
    logic [7:0] n_sel;
    if (a[31:4] != BASE[31:4]) return;
    case (a[3:2])
      2'd0: begin
        n_en  = be[0] ? d[0] : m_en;
        n_sel = be[1] ? d[15:8] : m_sel;
        if (int'(n_sel) >= NP) begin
          m_err = 1'b1;
        end else begin
          if (n_en && (!m_en || n_sel != m_sel)) begin
            m_entry = cycle;
            m_glen  = m_guard;
          end
          m_en  = n_en;
          m_sel = n_sel;
        end
      end
      2'd1: if (be[0] && d[0]) m_err = 1'b0;
      2'd2: if (be[0]) m_guard = d[7:0];
      default: ;
    endcase
  endtask

  task automatic rand_proj();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
    proj_out = t[NP*PADS-1:0];
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
    proj_oeb = t[NP*PADS-1:0];
    io_in = {6'($urandom), $urandom};
  endtask

  task automatic check_pads();
    int s = exp_state();
    logic [PADS-1:0] eo = '0;
    logic [PADS-1:0] eb = '1;
    logic [NP-1:0]   er = '1;
    if (s == 2) begin
      eo = proj_out[int'(m_sel)*PADS +: PADS];
      eb = proj_oeb[int'(m_sel)*PADS +: PADS];
      er[m_sel[1:0]] = 1'b0;
    end
    chk("io_out", 160'(io_out), 160'(eo));
    chk("io_oeb", 160'(io_oeb), 160'(eb));
    chk("proj_rst", 160'(proj_rst), 160'(er));
    chk("proj_in", 160'(proj_in), 160'({NP{io_in}}));
  endtask

  task automatic edge2();
    @(posedge clk);
    #1;
    if (rand_pads) rand_proj();
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      edge2();
      check_pads();
    end
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; sel = '0; dat_i = '0; adr = '0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    adr = a; dat_i = d; sel = be; we = 1; cyc = 1; stb = 1;
    edge2();
    model_write(a, d, be);
    chk("wr_ack", 160'(ack), 160'(1'b1));
    check_pads();
    bus_idle();
    step(1);
  endtask

  task automatic wb_read(input logic [31:0] a, input string tag);
    logic [31:0] e = exp_read(a);
    adr = a; sel = 4'hf; we = 0; cyc = 1; stb = 1;
    edge2();
    chk({tag, "_ack"}, 160'(ack), 160'(1'b1));
    chk(tag, 160'(dat_o), 160'(e));
    check_pads();
    bus_idle();
    step(1);
  endtask

  initial begin
    logic [31:0] e;
    bus_idle();
    rand_pads = 0;
    proj_out = '0; proj_oeb = '1; io_in = '0;
    rand_proj();
    proj_out[2*PADS +: PADS] = 38'h15;
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    // 1: reset state
    check_pads();
    chk("rst_ack", 160'(ack), 160'(1'b0));
    chk("rst_dat", 160'(dat_o), 160'(0));
    wb_read(BASE + 32'h4, "rst_status");
    wb_read(BASE + 32'h8, "rst_guard");
    wb_read(BASE + 32'hc, "reserved");

    // 2: enable project 2, watch the 17-cycle guard then RUN
    wb_write(BASE, 32'h0201, 4'b0011);
    wb_read(BASE + 32'h4, "status_guard");
    step(18);
    wb_read(BASE + 32'h4, "status_run");
    chk("run_out_p2", 160'(io_out), 160'(38'h15));

    // 3: switch to project 1; select changes mid-guard restart the count
    wb_write(BASE, 32'h0101, 4'b0011);
    step(5);
    wb_write(BASE, 32'h0301, 4'b0011);
    step(4);
    wb_write(BASE, 32'h0101, 4'b0011);
    step(20);
    wb_write(BASE, 32'h0101, 4'b0011);
    step(2);

    // 4: invalid select is acked but ignored, ERR is W1C
    wb_write(BASE, 32'h0901, 4'b0011);
    wb_read(BASE, "ctrl_after_bad");
    wb_read(BASE + 32'h4, "status_err");
    wb_write(BASE + 32'h4, 32'h1, 4'b0001);
    wb_read(BASE + 32'h4, "status_err_clr");

    // 5: zero-length guard, then disable
    wb_write(BASE + 32'h8, 32'h0, 4'b0001);
    wb_write(BASE, 32'h0100, 4'b0011);
    wb_write(BASE, 32'h0101, 4'b0011);
    step(2);
    wb_write(BASE, 32'h0100, 4'b0001);
    step(1);

    // 6: held strobe gives alternating acks; misses never acked
    e = exp_read(BASE);
    adr = BASE; sel = 4'hf; we = 0; cyc = 1; stb = 1;
    #1;
    chk("held_ack0", 160'(ack), 160'(1'b0));
    for (int k = 0; k < 4; k++) begin
      edge2();
      chk("held_ack", 160'(ack), 160'((k % 2) == 0));
      chk("held_dat", 160'(dat_o), 160'(((k % 2) == 0) ? e : 32'h0));
    end
    bus_idle();
    step(1);
    adr = BASE + 32'h10; cyc = 1; stb = 1; we = 1; dat_i = 32'h0301; sel = 4'hf;
    for (int k = 0; k < 3; k++) begin
      edge2();
      chk("miss_ack", 160'(ack), 160'(1'b0));
      check_pads();
    end
    bus_idle();
    step(1);

    // Random traffic
    rand_pads = 1;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0, 1: wb_write(BASE, {16'h0, 8'($urandom_range(0, 5)), 7'h0, 1'($urandom)},
                       4'($urandom));
        2: wb_write(BASE + 32'h8, 32'($urandom_range(0, 6)), 4'($urandom));
        3: wb_write(BASE + 32'h4, 32'($urandom), 4'($urandom));
        4: wb_read(BASE + {28'h0, 2'($urandom), 2'b00}, "rand_read");
        default: step($urandom_range(1, 4));
      endcase
    end

    // Reset while running returns to IDLE with default registers
    rand_pads = 0;
    wb_write(BASE + 32'h8, 32'h2, 4'b0001);
    wb_write(BASE, 32'h0300, 4'b0011);
    wb_write(BASE, 32'h0301, 4'b0011);
    step(4);
    chk("pre_rst_run", 160'(exp_state()), 160'(2));
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    #1;
    check_pads();
    wb_read(BASE, "post_rst_ctrl");
    wb_read(BASE + 32'h8, "post_rst_guard");
    wb_read(BASE + 32'h4, "post_rst_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
